phys_reg_free_list: RTL and testbench

Physical-register allocator for the rename stage, directly upstream of the 128-entry physical register file. It hands out free physical tags (P32..P127 at reset) to renamed destinations, and these tags are the rd values that drive the register file's set-not-ready inputs. It takes back tags released at commit. It supports one branch checkpoint so that allocations made after a mispredicted branch are reclaimed in a single cycle.

---
 rtl/phys_reg_free_list_if.sv | 27 ++
 rtl/phys_reg_free_list.sv | 93 +++++++++
 tb/tb_phys_reg_free_list.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/phys_reg_free_list_if.sv
// Handshake bundle between the rename/commit logic (master) and the physical
// register free list (slave).
interface phys_reg_free_list_if #(
  parameter int TAG_W = 7,
  parameter int CNT_W = 7
);
  logic             alloc_req;
  logic             alloc_valid;
  logic [TAG_W-1:0] alloc_preg;
  logic             free_valid;
  logic [TAG_W-1:0] free_preg;
  logic             ckpt_save;
  logic             ckpt_restore;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             overflow_err;

  modport master (
    output alloc_req, free_valid, free_preg, ckpt_save, ckpt_restore,
    input  alloc_valid, alloc_preg, count, empty, overflow_err
  );

  modport slave (
    input  alloc_req, free_valid, free_preg, ckpt_save, ckpt_restore,
    output alloc_valid, alloc_preg, count, empty, overflow_err
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags for the rename stage, with a
// single branch checkpoint that rolls the head back on a mispredict.
module phys_reg_free_list #(
  parameter int NUM_PREGS = 128,
  parameter int NUM_AREGS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  phys_reg_free_list_if.slave   fl
);
  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int TAG_W = $clog2(NUM_PREGS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;

  logic [TAG_W-1:0] mem [DEPTH];
  ptr_t             head, tail, ckpt_head;
  logic [CNT_W-1:0] count_q, alloc_since;
  logic             ckpt_valid, overflow_q;

  logic             alloc_fire, free_req, free_fire;
  logic             restore_fire, save_fire;
  logic [CNT_W:0]   base_count, count_sum;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fl.alloc_valid  = (count_q != '0) && reset && !fl.ckpt_restore;
  assign fl.alloc_preg   = mem[head];
  assign fl.count        = count_q;
  assign fl.empty        = (count_q == '0);
  assign fl.overflow_err = overflow_q;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    restore_fire = fl.ckpt_restore && ckpt_valid;
    save_fire    = fl.ckpt_save && !fl.ckpt_restore;
    alloc_fire   = fl.alloc_req && fl.alloc_valid;
    base_count   = {1'b0, count_q};
    // A restore returns the window's tags first, so a same-cycle free must fit
    // behind them or it would overwrite a rolled-back slot.
    if (restore_fire) begin
      base_count = {1'b0, count_q} + {1'b0, alloc_since};
      if (base_count > DEPTH_W) base_count = DEPTH_W;
    end
    free_req  = fl.free_valid && (fl.free_preg != '0);
    free_fire = free_req && (base_count < DEPTH_W);
    count_sum = base_count + {{CNT_W{1'b0}}, free_fire} - {{CNT_W{1'b0}}, alloc_fire};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the tag storage is reset because its initial contents (P32..P127)
      // are architecturally visible, not just the pointers.
      for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_W'(NUM_AREGS + i);
      head        <= '0;
      tail        <= '0;
      count_q     <= DEPTH_C;
      ckpt_head   <= '0;
      alloc_since <= '0;
      ckpt_valid  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      count_q <= count_sum[CNT_W-1:0];
      if (free_fire) begin
        mem[tail] <= fl.free_preg;
        tail      <= next_ptr(tail);
      end
      if (free_req && !free_fire) overflow_q <= 1'b1;

      if (restore_fire) begin
        head        <= ckpt_head;
        alloc_since <= '0;
        ckpt_valid  <= 1'b0;
      end else begin
        if (alloc_fire) head <= next_ptr(head);
        if (save_fire) begin
          ckpt_head   <= head;
          alloc_since <= alloc_fire ? CNT_W'(1) : '0;
          ckpt_valid  <= 1'b1;
        end else if (ckpt_valid && alloc_fire && alloc_since != DEPTH_C) begin
          alloc_since <= alloc_since + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: a queue-based model predicts each
// cycle's outputs and a negedge monitor compares them against the DUT.
module tb_phys_reg_free_list;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  phys_reg_free_list_if bus ();

  phys_reg_free_list dut (
    .clk   (clk),
    .reset (reset),
    .fl    (bus)
  );

  typedef struct {
    bit         av;
    logic [6:0] preg;
    int         cnt;
    bit         emp;
    bit         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: the list is an ordered queue of tags, head first.
  int free_q[$];
  int since_q[$];   // tags handed out since the live checkpoint, oldest first
  int busy[$];      // tags allocated before any live checkpoint and not yet freed
  bit m_ckpt;
  bit m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    free_q.delete();
    since_q.delete();
    busy.delete();
    for (int i = 0; i < 96; i++) free_q.push_back(32 + i);
    m_ckpt = 1'b0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void drop_busy(input int tag);
    for (int i = 0; i < busy.size(); i++) begin
      if (busy[i] == tag) begin
        busy.delete(i);
        return;
      end
    end
  endfunction

  // One clock cycle: drive inputs, predict this cycle's outputs, then advance
  // the model to the state after the next posedge.
  task automatic cycle(input bit rst_i, input bit req, input bit fv, input int fp,
                       input bit sv, input bit rs);
    exp_t e;
    bit   grant, restore_ok, free_req, free_fire;
    int   tag, base;
    @(posedge clk);
    #1;
    reset            = rst_i;
    bus.alloc_req    = req;
    bus.free_valid   = fv;
    bus.free_preg    = 7'(fp);
    bus.ckpt_save    = sv;
    bus.ckpt_restore = rs;

    e.av   = rst_i && (free_q.size() != 0) && !rs;
    e.preg = e.av ? 7'(free_q[0]) : 7'd0;
    e.cnt  = free_q.size();
    e.emp  = (free_q.size() == 0);
    e.ovf  = m_ovf;
    exp_q.push_back(e);

    if (!rst_i) begin
      model_reset();
      return;
    end
    grant      = req && e.av;
    restore_ok = rs && m_ckpt;
    base       = free_q.size();
    if (restore_ok) begin
      base = free_q.size() + since_q.size();
      if (base > 96) base = 96;
    end
    free_req  = fv && (fp != 0);
    free_fire = free_req && (base < 96);
    if (free_req && !free_fire) m_ovf = 1'b1;

    tag = 0;
    if (grant) tag = free_q.pop_front();
    if (restore_ok) begin
      for (int i = since_q.size() - 1; i >= 0; i--) free_q.push_front(since_q[i]);
      since_q.delete();
      m_ckpt = 1'b0;
    end
    if (free_fire) begin
      free_q.push_back(fp);
      drop_busy(fp);
    end
    if (sv && !rs) begin
      foreach (since_q[i]) busy.push_back(since_q[i]);
      since_q.delete();
      m_ckpt = 1'b1;
      if (grant) since_q.push_back(tag);
    end else if (grant) begin
      if (m_ckpt) since_q.push_back(tag);
      else        busy.push_back(tag);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("alloc_valid", 32'(bus.alloc_valid), 32'(e.av));
        if (e.av) check("alloc_preg", 32'(bus.alloc_preg), 32'(e.preg));
        check("count", 32'(bus.count), 32'(e.cnt));
        check("empty", 32'(bus.empty), 32'(e.emp));
        check("overflow_err", 32'(bus.overflow_err), 32'(e.ovf));
      end
    end
  end

  initial begin
    reset            = 1'b0;
    bus.alloc_req    = 1'b0;
    bus.free_valid   = 1'b0;
    bus.free_preg    = '0;
    bus.ckpt_save    = 1'b0;
    bus.ckpt_restore = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // Drain all 96 tags, then one request that must stall.
    for (int i = 0; i < 97; i++) cycle(1, 1, 0, 0, 0, 0);

    // Free P40 while empty with the request held: granted only a cycle later.
    cycle(1, 1, 1, 40, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // Build count=10, then simultaneous alloc and free of P50, then drain.
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 60 + i, 0, 0);
    cycle(1, 1, 1, 50, 0, 0);
    for (int i = 0; i < 11; i++) cycle(1, 1, 0, 0, 0, 0);

    // Checkpoint with same-cycle alloc, three more, then restore with a free.
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 7, 0, 1);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);

    // Reset mid-restore after allocs, frees and a pending checkpoint.
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 33, 1, 0);
    cycle(1, 1, 1, 35, 0, 0);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0);

    // Tag 0 free is ignored; save and restore together lets restore win.
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0);

    // Randomised traffic with legal frees, checkpoints and restores.
    for (int n = 0; n < 3000; n++) begin
      bit req, fv, sv, rs;
      int fp, r;
      req = ($urandom_range(99) < 55);
      fv  = 1'b0;
      fp  = 0;
      r   = $urandom_range(99);
      if (r < 5) begin
        fv = 1'b1;
      end else if (r < 50 && busy.size() != 0) begin
        fv = 1'b1;
        fp = busy[$urandom_range(busy.size() - 1)];
      end
      r  = $urandom_range(99);
      sv = (r < 6);
      rs = (r >= 6 && r < 10);
      cycle(1, req, fv, fp, sv, rs);
    end
    cycle(1, 0, 0, 0, 0, 0);

    @(posedge clk);
    @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
